// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - base types and stage payload typedefs shared by the pipeline stage registers
package common;

    typedef logic        u1;
    typedef logic [31:0] u32;

endpackage

package pipes;

    import common::*;

    // Default epoch width; a stage register may widen it through its EW parameter.
    localparam int EPOCH_W = 2;

    typedef logic [EPOCH_W-1:0] epoch_t;

    // F/D boundary payload (64 bits, matches the default W).
    typedef struct packed {
        u32 pc;
        u32 instr;
    } fetch_data_t;

    // D/E boundary payload.
    typedef struct packed {
        u32 pc;
        u32 imm;
    } decode_data_t;

    // E/M boundary payload.
    typedef struct packed {
        u32 alu_result;
        u32 store_data;
    } exec_data_t;

    // M/W boundary payload.
    typedef struct packed {
        u32 wb_data;
        u32 wb_info;
    } mem_data_t;

endpackage

// File: rtl/pipe_stage_perf.sv
// rtl/pipe_stage_perf.sv - hold/flush/bubble event counters for one pipeline stage register
module pipe_stage_perf
    import common::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hold_evt,
    input  logic flush_evt,
    input  logic bubble_evt,
    output u32   perf_hold_cnt,
    output u32   perf_flush_cnt,
    output u32   perf_bubble_cnt
);

    // Free-running wrapping counters, one per event class.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hold_cnt   <= '0;
            perf_flush_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (hold_evt)   perf_hold_cnt   <= perf_hold_cnt + 32'd1;
            if (flush_evt)  perf_flush_cnt  <= perf_flush_cnt + 32'd1;
            if (bubble_evt) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline stage register with epochs and sticky deferred flush (PIPE_STAGE_REG_PERF_EN adds perf counters)
module pipe_stage_reg
    import common::*;
#(
    parameter int W              = 64,
    parameter int NF             = 2,
    parameter int NS             = 1,
    parameter int EW             = 2,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    input  logic          hard_stall,
    input  logic [NS-1:0] soft_stall,
    input  logic [NF-1:0] flush,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    output logic [EW-1:0] out_epoch,
    output logic          flush_pending,
`ifdef PIPE_STAGE_REG_PERF_EN
    output u32            perf_hold_cnt,
    output u32            perf_flush_cnt,
    output u32            perf_bubble_cnt,
`endif
    output logic          in_ready
);

    logic          flush_any;
    logic          soft_any;
    logic          apply_flush;
    logic [EW-1:0] epoch_cur;

    assign flush_any = |flush;
    assign soft_any  = |soft_stall;

    // A live flush and a deferred one merge into a single flush action.
    assign apply_flush = flush_any | flush_pending;

    // Capture happens only when nothing higher in priority claims the cycle.
    assign in_ready = !reset && !hard_stall && !apply_flush && !soft_any;

    // Stage state update in priority order: reset, hard stall, flush, soft stall, advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_epoch     <= '0;
            epoch_cur     <= '0;
            flush_pending <= 1'b0;
        end else if (hard_stall) begin
            // Frozen; remember any flush so it is not lost behind the handshake.
            if (flush_any) flush_pending <= 1'b1;
        end else if (apply_flush) begin
            out_valid     <= 1'b0;
            if (CLEAR_ON_FLUSH) out_data <= '0;
            epoch_cur     <= epoch_cur + EW'(1);
            flush_pending <= 1'b0;
        end else if (!soft_any) begin
            out_data  <= in_data;
            out_valid <= in_valid;
            out_epoch <= epoch_cur;
        end
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    logic hold_evt;
    logic flush_evt;
    logic bubble_evt;

    assign hold_evt   = !reset && (hard_stall || (!apply_flush && soft_any));
    assign flush_evt  = !reset && !hard_stall && apply_flush;
    assign bubble_evt = in_ready && !in_valid;

    pipe_stage_perf u_perf (
        .clk             (clk),
        .reset           (reset),
        .hold_evt        (hold_evt),
        .flush_evt       (flush_evt),
        .bubble_evt      (bubble_evt),
        .perf_hold_cnt   (perf_hold_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. Successor to the fixed fetch/decode stage register; used at every stage boundary (F/D, D/E, E/M, M/W).
- Carries an arbitrary payload, a valid bit and a flush epoch tag.
- Takes a vector of flush sources and a vector of soft-stall sources.
- Adds a sticky pending-flush latch, so a flush that arrives during a memory-handshake stall is not lost.

Parameters:
- W, 64, payload width in bits
- NF, 2, number of flush sources (e.g. branch redirect, CSR/trap)
- NS, 1, number of soft-stall sources (e.g. load-use hazard)
- EW, 2, epoch tag width; wraps modulo 2^EW
- CLEAR_ON_FLUSH, 1, 1: payload zeroed on flush; 0: payload held, only valid cleared

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- in_data  in  W  payload from upstream stage
- in_valid  in  1  upstream payload valid
- hard_stall  in  1  bus/memory handshake stall; freezes the stage, overrides flush
- soft_stall  in  NS  hazard stalls; OR-reduced; lower priority than flush
- flush  in  NF  flush requests; OR-reduced
- out_data  out  W  registered payload
- out_valid  out  1  registered valid
- out_epoch  out  EW  epoch in which out_data was captured
- flush_pending  out  1  a flush was deferred by hard_stall and is still outstanding
- in_ready  out  1  combinational; 1 in exactly the cycles in_data/in_valid are captured

Behaviour:
- Reset values: out_data=0, out_valid=0, out_epoch=0, flush_pending=0, internal current epoch=0.
- Latency: 1 cycle from in_* to out_* when advancing.
- Let F = |flush, S = |soft_stall, P = flush_pending.
- Per-cycle priority, evaluated at posedge:
  - 1) reset: all state to reset values; overrides everything.
  - 2) hard_stall: all outputs hold. If F, set P<=1 (sticky; repeated flushes during the stall still produce one pending flush).
  - 3) F or P: out_valid<=0; out_data<=0 if CLEAR_ON_FLUSH, else hold. Current epoch<=epoch+1 (wraps at 2^EW). P<=0. F and P together cause a single increment.
  - 4) S: hold all outputs.
  - 5) else: out_data<=in_data, out_valid<=in_valid, out_epoch<=current epoch.
- in_ready = !reset & !hard_stall & !F & !P & !S.
- Upstream must hold in_data/in_valid while in_ready=0.
- out_epoch is sampled only on advance, so a held entry keeps its original epoch. Downstream compares it against the live epoch to discard stale results.
- A flush arriving in the same cycle hard_stall drops is applied immediately (case 3); the flush is not deferred.
- Reset asserted while P=1 clears P; no flush is applied after reset.
- The pipeline register state is exactly: out_data, out_valid, out_epoch, current epoch and P.

Optional Feature:
- PIPE_STAGE_REG_PERF_EN defined: adds three outputs, each a 32-bit wrapping counter, reset to 0:
  - perf_hold_cnt: increments on cycles taking case 2 or case 4
  - perf_flush_cnt: increments on each applied flush (case 3)
  - perf_bubble_cnt: increments on case-5 cycles with in_valid=0
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package pipes: epoch_t (logic [EW-1:0]); stage payload struct typedefs (fetch_data_t etc.) used as W instances.
- Package common: u1/u32 base types.
- One sub-module, pipe_stage_perf, holds the three counters. It is instantiated only under PIPE_STAGE_REG_PERF_EN.

Test Plan:
- Reset with in_data=0xDEAD, in_valid=1 -> out_data=0, out_valid=0, out_epoch=0, flush_pending=0, in_ready=0.
- Advance 3 cycles with in_data=0x11,0x22,0x33, valid=1 -> out_data follows with 1-cycle lag; in_ready=1 each cycle; out_epoch=0.
- soft_stall=1 for 2 cycles with out_data=0x22 -> out_data holds 0x22; in_ready=0. Flush=01 in stall cycle 2 -> next cycle out_valid=0, out_data=0, epoch becomes 1.
- hard_stall=1 for 3 cycles, flush=10 in cycle 1 -> outputs frozen; flush_pending=1 from cycle 2. hard_stall drops -> one flush cycle (out_valid=0, epoch+1), then advance resumes.
- Flush pulse on 4 successive idle cycles with EW=2 -> epoch sequence 1,2,3,0. With CLEAR_ON_FLUSH=0, out_data retains its last value.
- PERF_EN: 5 advances (2 with in_valid=0), 3 soft-stall cycles, 1 flush -> perf_bubble_cnt=2, perf_hold_cnt=3, perf_flush_cnt=1.
